// File: rtl/vec_mem_sequencer.sv
// -----------------------------------------------------------------------------
// vec_mem_sequencer
//
// Serialises one LANES-wide vector load or store, held in the M stage, into
// single-word accesses on the data-memory port. It is the only master on that
// port. While the vector op is in flight the pipeline is stalled. Load lanes
// are collected into ReadDataM, which feeds the M/W pipeline register.
//
// Ports
//   CLK, RST_N   : clock (rising edge) and asynchronous active-low reset
//   StartM       : M stage holds a vector memory op (held while StallM=1)
//   MemWriteM    : 1 = store, 0 = load (sampled with StartM)
//   BaseAddrM    : byte base address; lane i uses BaseAddrM + 4*i
//   WriteDataM   : store vector, one DATA_W word per lane
//   StallM       : freeze F/D/E/M and insert a bubble into M/W
//   DoneM        : one-cycle completion pulse (pipeline advances this cycle)
//   ReadDataM    : assembled load vector (register)
//   MemReq/MemWe/MemAddr/MemWData : word request towards data memory
//   MemGnt       : memory accepts the current request
//   MemRValid/MemRData : read response (at most one read outstanding)
// -----------------------------------------------------------------------------
module vec_mem_sequencer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          StartM,
  input  logic                          MemWriteM,
  input  logic [ADDR_W-1:0]             BaseAddrM,
  input  logic [LANES-1:0][DATA_W-1:0]  WriteDataM,
  output logic                          StallM,
  output logic                          DoneM,
  output logic [LANES-1:0][DATA_W-1:0]  ReadDataM,
  output logic                          MemReq,
  output logic                          MemWe,
  output logic [ADDR_W-1:0]             MemAddr,
  output logic [DATA_W-1:0]             MemWData,
  input  logic                          MemGnt,
  input  logic                          MemRValid,
  input  logic [DATA_W-1:0]             MemRData
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [LANE_W-1:0]              r_lane;
  logic [LANE_W-1:0]              w_lane_nxt;
  logic                           r_we;
  logic [ADDR_W-1:0]              r_base;
  logic [LANES-1:0][DATA_W-1:0]   r_wdata;
  logic [LANES-1:0][DATA_W-1:0]   r_rdata;
  logic                           w_latch;
  logic                           w_rd_capture;
  logic [ADDR_W-1:0]              w_lane_off;
  logic [ADDR_W-1:0]              w_addr;

  // Byte offset of the current lane (lane * 4); the add wraps modulo 2^ADDR_W
  // and leaves the base's low two bits untouched.
  assign w_lane_off = {{(ADDR_W-LANE_W-2){1'b0}}, r_lane, 2'b00};
  assign w_addr     = r_base + w_lane_off;
  assign ReadDataM  = r_rdata;

  // Next-state, lane counter and all control outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_lane_nxt   = r_lane;
    w_latch      = 1'b0;
    w_rd_capture = 1'b0;
    StallM       = 1'b0;
    DoneM        = 1'b0;
    MemReq       = 1'b0;
    MemWe        = 1'b0;
    MemAddr      = {ADDR_W{1'b0}};
    MemWData     = {DATA_W{1'b0}};

    case (r_state)
      S_IDLE: begin
        // Stall is raised combinationally so the op freezes in its first M cycle.
        if (StartM) begin
          StallM      = 1'b1;
          w_latch     = 1'b1;
          w_lane_nxt  = {LANE_W{1'b0}};
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_ISSUE: begin
        StallM   = 1'b1;
        MemReq   = 1'b1;
        MemWe    = r_we;
        MemAddr  = w_addr;
        MemWData = r_wdata[r_lane];
        if (MemGnt) begin
          if (r_we) begin
            if (r_lane == LAST_LANE) begin
              w_state_nxt = S_DONE;
            end else begin
              w_lane_nxt  = r_lane + LANE_W'(1);
              w_state_nxt = S_ISSUE;
            end
          end else begin
            w_state_nxt = S_WAIT_R;
          end
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end

      S_WAIT_R: begin
        StallM = 1'b1;
        if (MemRValid) begin
          w_rd_capture = 1'b1;
          if (r_lane == LAST_LANE) begin
            w_state_nxt = S_DONE;
          end else begin
            w_lane_nxt  = r_lane + LANE_W'(1);
            w_state_nxt = S_ISSUE;
          end
        end else begin
          w_state_nxt = S_WAIT_R;
        end
      end

      S_DONE: begin
        // StartM is deliberately ignored: the pipeline advances this cycle and
        // the next op is taken on the following IDLE cycle.
        DoneM       = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_lane_nxt  = {LANE_W{1'b0}};
      end
    endcase
  end

  // FSM state and lane counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_lane  <= {LANE_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

  // Operand latch, loaded once when the op is accepted in IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_we    <= 1'b0;
      r_base  <= {ADDR_W{1'b0}};
      r_wdata <= '0;
    end else if (w_latch) begin
      r_we    <= MemWriteM;
      r_base  <= BaseAddrM;
      r_wdata <= WriteDataM;
    end else begin
      r_we    <= r_we;
      r_base  <= r_base;
      r_wdata <= r_wdata;
    end
  end

  // Load-vector assembly: only the lane being waited on is written, so other
  // lanes (and the whole vector during stores) keep their previous values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rdata <= '0;
    end else if (w_rd_capture) begin
      r_rdata[r_lane] <= MemRData;
    end else begin
      r_rdata <= r_rdata;
    end
  end

endmodule
